// File: rtl/cascade_down_counter_bcd.sv
// cascade_down_counter_bcd: multi-digit cascaded down-counter with per-digit modulus and borrow chain
module cascade_down_counter_bcd #(
   parameter int          DIGITS       = 4,
   parameter logic [31:0] MODS         = 32'h0000_6A6A,
   parameter bit          STOP_AT_ZERO = 1'b1
) (
   input  logic                clk,
   input  logic                clear,
   input  logic                en,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_value,
   output logic [4*DIGITS-1:0] count,
   output logic [DIGITS-1:0]   digit_zero,
   output logic                zero,
   output logic                tc,
   output logic                done
);
   localparam int W = 4 * DIGITS;
   localparam logic [W-1:0] ONE = 1;
   logic [W-1:0]      dec;
   logic [W-1:0]      clamped;
   logic [DIGITS-1:0] step;

   // a modulus nibble of 0 means 16, so MOD-1 wraps naturally to 4'hF
   function automatic logic [3:0] max_of(input int i);
      return MODS[4*i +: 4] - 4'd1;
   endfunction

   always_comb begin
      dec = count;
      clamped = load_value;
      step = '0;
      digit_zero = '0;
      for (int i = 0; i < DIGITS; i++) begin
         digit_zero[i] = count[4*i +: 4] == 4'd0;
         step[i] = ~|(count & ((ONE << (4*i)) - ONE));
         dec[4*i +: 4] = !step[i] ? count[4*i +: 4] :
                         digit_zero[i] ? max_of(i) : count[4*i +: 4] - 4'd1;
         clamped[4*i +: 4] = load_value[4*i +: 4] > max_of(i) ? max_of(i) : load_value[4*i +: 4];
      end
   end

   assign zero = ~|count;
   assign tc = zero & en;

   always_ff @(posedge clk or negedge clear)
      if (!clear) begin
         count <= '0;
         done <= 1'b0;
      end else begin
         count <= !load ? clamped : (en && !(zero && STOP_AT_ZERO)) ? dec : count;
         done <= load && en && !zero && dec == '0;
      end
endmodule

// File: tb/tb_cascade_down_counter_bcd.sv
// tb_cascade_down_counter_bcd: vector table plus scoreboard against a mixed-radix reference model
module tb_cascade_down_counter_bcd;
   logic        clk, clear, en, load;
   logic [15:0] load_value;
   logic [15:0] cnt_a, cnt_w;
   logic [7:0]  cnt_b;
   logic [3:0]  dz_a, dz_w;
   logic [1:0]  dz_b;
   logic        z_a, z_w, z_b, tc_a, tc_w, tc_b, dn_a, dn_w, dn_b;

   cascade_down_counter_bcd dut_a (
      .clk(clk), .clear(clear), .en(en), .load(load), .load_value(load_value),
      .count(cnt_a), .digit_zero(dz_a), .zero(z_a), .tc(tc_a), .done(dn_a));

   cascade_down_counter_bcd #(.STOP_AT_ZERO(1'b0)) dut_w (
      .clk(clk), .clear(clear), .en(en), .load(load), .load_value(load_value),
      .count(cnt_w), .digit_zero(dz_w), .zero(z_w), .tc(tc_w), .done(dn_w));

   cascade_down_counter_bcd #(.DIGITS(2), .MODS(32'h3A), .STOP_AT_ZERO(1'b0)) dut_b (
      .clk(clk), .clear(clear), .en(en), .load(load), .load_value(load_value[7:0]),
      .count(cnt_b), .digit_zero(dz_b), .zero(z_b), .tc(tc_b), .done(dn_b));

   typedef struct {
      logic        ld_n;
      logic        en;
      logic [15:0] lv;
      logic [15:0] exp_cnt;
      logic        exp_done;
   } vec_t;

   typedef struct {
      logic [31:0] c_a, c_w, c_b;
      logic        d_a, d_w, d_b;
   } exp_t;

   exp_t        q[$];
   logic [31:0] m_a, m_w, m_b;
   int          checks = 0, failures = 0, pulse_a = 0, pulse_b = 0;
   vec_t        tbl[16];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int unsigned mod_of(input logic [31:0] mods, input int i);
      return mods[4*i +: 4] == 4'd0 ? 16 : int'(mods[4*i +: 4]);
   endfunction

   // reference decrement: treat digits as one mixed-radix integer and subtract 1
   function automatic logic [31:0] mdl_dec(input logic [31:0] c, input int nd, input logic [31:0] mods, input bit stop);
      int unsigned v, w, m;
      logic [31:0] r;
      v = 0;
      w = 1;
      r = '0;
      for (int i = 0; i < nd; i++) begin
         m = mod_of(mods, i);
         v += int'(c[4*i +: 4]) * w;
         w *= m;
      end
      v = v == 0 ? (stop ? 0 : w - 1) : v - 1;
      for (int i = 0; i < nd; i++) begin
         m = mod_of(mods, i);
         r[4*i +: 4] = 4'(v % m);
         v /= m;
      end
      return r;
   endfunction

   function automatic logic [31:0] mdl_next(input logic [31:0] c, input logic ld_n, input logic e,
                                            input logic [31:0] lv, input int nd, input logic [31:0] mods,
                                            input bit stop, output logic d);
      logic [31:0] r;
      r = '0;
      d = 1'b0;
      if (!ld_n) begin
         for (int i = 0; i < nd; i++)
            r[4*i +: 4] = int'(lv[4*i +: 4]) > mod_of(mods, i) - 1 ? 4'(mod_of(mods, i) - 1) : lv[4*i +: 4];
      end else if (e) begin
         r = mdl_dec(c, nd, mods, stop);
         d = c != 0 && r == 0;
      end else
         r = c;
      return r;
   endfunction

   function automatic logic [31:0] dzm(input logic [31:0] c, input int nd);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < nd; i++) r[i] = c[4*i +: 4] == 4'd0;
      return r;
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic chk_inst(input string n, input logic [31:0] c, input logic d, input logic z,
                           input logic t, input logic [31:0] dz, input logic [31:0] ec,
                           input logic ed, input int nd);
      chk({n, ".count"}, c, ec);
      chk({n, ".done"}, 32'(d), 32'(ed));
      chk({n, ".zero"}, 32'(z), 32'(ec == 0));
      chk({n, ".tc"}, 32'(t), 32'(ec == 0 && en));
      chk({n, ".digit_zero"}, dz, dzm(ec, nd));
   endtask

   task automatic step(input logic ld_n, input logic e, input logic [15:0] lv);
      exp_t x;
      load = ld_n;
      en = e;
      load_value = lv;
      x.c_a = mdl_next(m_a, ld_n, e, 32'(lv), 4, 32'h6A6A, 1'b1, x.d_a);
      x.c_w = mdl_next(m_w, ld_n, e, 32'(lv), 4, 32'h6A6A, 1'b0, x.d_w);
      x.c_b = mdl_next(m_b, ld_n, e, 32'(lv[7:0]), 2, 32'h3A, 1'b0, x.d_b);
      m_a = x.c_a;
      m_w = x.c_w;
      m_b = x.c_b;
      q.push_back(x);
      @(posedge clk);
      #1;
      x = q.pop_front();
      pulse_a += int'(dn_a);
      pulse_b += int'(dn_b);
      chk_inst("a", 32'(cnt_a), dn_a, z_a, tc_a, 32'(dz_a), x.c_a, x.d_a, 4);
      chk_inst("w", 32'(cnt_w), dn_w, z_w, tc_w, 32'(dz_w), x.c_w, x.d_w, 4);
      chk_inst("b", 32'(cnt_b), dn_b, z_b, tc_b, 32'(dz_b), x.c_b, x.d_b, 2);
   endtask

   initial begin
      tbl = '{
         '{1'b0, 1'b1, 16'hFCB9, 16'h5959, 1'b0},
         '{1'b1, 1'b1, 16'h0000, 16'h5958, 1'b0},
         '{1'b0, 1'b0, 16'h0230, 16'h0230, 1'b0},
         '{1'b1, 1'b0, 16'hFFFF, 16'h0230, 1'b0},
         '{1'b1, 1'b0, 16'h1234, 16'h0230, 1'b0},
         '{1'b1, 1'b0, 16'h0000, 16'h0230, 1'b0},
         '{1'b1, 1'b0, 16'h5555, 16'h0230, 1'b0},
         '{1'b1, 1'b0, 16'hAAAA, 16'h0230, 1'b0},
         '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0},
         '{1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0},
         '{1'b0, 1'b1, 16'h1000, 16'h1000, 1'b0},
         '{1'b1, 1'b1, 16'h0000, 16'h0959, 1'b0},
         '{1'b0, 1'b0, 16'h0001, 16'h0001, 1'b0},
         '{1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1},
         '{1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0},
         '{1'b0, 1'b1, 16'hF9F9, 16'h5959, 1'b0}
      };
      clear = 1'b0;
      en = 1'b0;
      load = 1'b1;
      load_value = '0;
      m_a = '0;
      m_w = '0;
      m_b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.count", 32'(cnt_a), 32'h0);
      chk("reset.zero", 32'(z_a), 32'h1);
      chk("reset.done", 32'(dn_a), 32'h0);
      chk("reset.digit_zero", 32'(dz_a), 32'hF);
      clear = 1'b1;

      // 01:00 countdown to zero, single done pulse, then hold
      step(1'b0, 1'b1, 16'h0100);
      chk("load_over_en", 32'(cnt_a), 32'h0100);
      step(1'b1, 1'b1, 16'h0000);
      chk("first_dec", 32'(cnt_a), 32'h0059);
      for (int i = 0; i < 59; i++) step(1'b1, 1'b1, 16'h0000);
      chk("reach_zero", 32'(cnt_a), 32'h0);
      chk("done_pulse", 32'(dn_a), 32'h1);
      step(1'b1, 1'b1, 16'h0000);
      chk("hold_done", 32'(dn_a), 32'h0);
      chk("hold_tc", 32'(tc_a), 32'h1);
      chk("wrap_all", 32'(cnt_w), 32'h5959);
      chk("wrap_done", 32'(dn_w), 32'h0);
      chk("pulse_count_a", 32'(pulse_a), 32'h1);

      for (int i = 0; i < 16; i++) begin
         step(tbl[i].ld_n, tbl[i].en, tbl[i].lv);
         chk($sformatf("tbl%0d.count", i), 32'(cnt_a), 32'(tbl[i].exp_cnt));
         chk($sformatf("tbl%0d.done", i), 32'(dn_a), 32'(tbl[i].exp_done));
      end

      // two-digit mod 10/3 counter wrapping through zero
      step(1'b0, 1'b0, 16'h0020);
      pulse_b = 0;
      for (int i = 0; i < 25; i++) step(1'b1, 1'b1, 16'h0000);
      chk("b_final", 32'(cnt_b), 32'h25);
      chk("pulse_count_b", 32'(pulse_b), 32'h1);

      // asynchronous clear mid-cycle while counting
      step(1'b0, 1'b1, 16'h0530);
      chk("preload", 32'(cnt_a), 32'h0530);
      en = 1'b1;
      load = 1'b1;
      #2;
      clear = 1'b0;
      #1;
      chk("async.count", 32'(cnt_a), 32'h0);
      chk("async.zero", 32'(z_a), 32'h1);
      chk("async.done", 32'(dn_a), 32'h0);
      chk("async.tc", 32'(tc_a), 32'h1);
      chk("async.b", 32'(cnt_b), 32'h0);
      m_a = '0;
      m_w = '0;
      m_b = '0;
      @(posedge clk);
      #1;
      clear = 1'b1;
      step(1'b1, 1'b1, 16'h0000);
      chk("resume_w", 32'(cnt_w), 32'h5959);
      chk("resume_b", 32'(cnt_b), 32'h29);
      step(1'b1, 1'b1, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
